// File: rtl/mem_access_unit.sv
// Data-memory access unit: one Avalon-MM transfer per load/store, stalls the core until it completes,
// builds byte enables / replicated store data and returns extended or merged load data.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rt_old,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        addr_error,
    output logic        bus_timeout,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rt_q, rt_d;
    logic        is_read_q, is_read_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] avm_address_q, avm_address_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_write_q, avm_write_d;
    logic [31:0] avm_writedata_q, avm_writedata_d;
    logic [3:0]  avm_byteenable_q, avm_byteenable_d;

    logic is_byte, is_half, is_lwlr, misaligned;

    // Shapes the raw read word into the register value for the latched load opcode and byte offset.
    function automatic logic [31:0] shape_load(input logic [5:0] op, input logic [1:0] o,
                                               input logic [31:0] w, input logic [31:0] rt);
        logic [15:0] lo;
        logic [31:0] r;
        case (o)
            2'd0:    lo = w[15:0];
            2'd1:    lo = w[23:8];
            2'd2:    lo = w[31:16];
            default: lo = {8'h00, w[31:24]};
        endcase
        case (op)
            OP_LB:   r = {{24{lo[7]}}, lo[7:0]};
            OP_LBU:  r = {24'h0, lo[7:0]};
            OP_LH:   r = {{16{lo[15]}}, lo};
            OP_LHU:  r = {16'h0, lo};
            OP_LWL: begin
                case (o)
                    2'd0:    r = {w[7:0],  rt[23:0]};
                    2'd1:    r = {w[15:0], rt[15:0]};
                    2'd2:    r = {w[23:0], rt[7:0]};
                    default: r = w;
                endcase
            end
            OP_LWR: begin
                case (o)
                    2'd0:    r = w;
                    2'd1:    r = {rt[31:24], w[31:8]};
                    2'd2:    r = {rt[31:16], w[31:16]};
                    default: r = {rt[31:8],  w[31:24]};
                endcase
            end
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        off_d            = off_q;
        rt_d             = rt_q;
        is_read_d        = is_read_q;
        wait_cnt_d       = wait_cnt_q;
        load_data_d      = load_data_q;
        avm_address_d    = avm_address_q;
        avm_read_d       = avm_read_q;
        avm_write_d      = avm_write_q;
        avm_writedata_d  = avm_writedata_q;
        avm_byteenable_d = avm_byteenable_q;
        stall            = 1'b0;
        addr_error       = 1'b0;
        bus_timeout      = 1'b0;

        // A store wins over a simultaneous load, so LWL/LWR merging only applies to pure reads.
        is_byte    = (opcode == OP_LB) || (opcode == OP_LBU) || (opcode == OP_SB);
        is_half    = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
        is_lwlr    = !mem_write && ((opcode == OP_LWL) || (opcode == OP_LWR));
        misaligned = is_half ? addr[0] : (!is_byte && !is_lwlr && (addr[1:0] != 2'b00));

        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    if (misaligned) begin
                        addr_error = 1'b1;
                    end else begin
                        stall         = 1'b1;
                        state_d       = REQ;
                        op_d          = opcode;
                        off_d         = addr[1:0];
                        rt_d          = rt_old;
                        is_read_d     = !mem_write;
                        wait_cnt_d    = '0;
                        avm_address_d = {addr[31:2], 2'b00};
                        avm_read_d    = !mem_write;
                        avm_write_d   = mem_write;
                        if (!mem_write) begin
                            avm_byteenable_d = 4'hF;
                            avm_writedata_d  = '0;
                        end else if (is_byte) begin
                            avm_byteenable_d = 4'b0001 << addr[1:0];
                            avm_writedata_d  = {4{store_data[7:0]}};
                        end else if (is_half) begin
                            avm_byteenable_d = addr[1] ? 4'b1100 : 4'b0011;
                            avm_writedata_d  = {2{store_data[15:0]}};
                        end else begin
                            avm_byteenable_d = 4'hF;
                            avm_writedata_d  = store_data;
                        end
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (!avm_waitrequest) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    state_d     = DONE;
                    if (is_read_q) begin
                        load_data_d = shape_load(op_q, off_q, avm_readdata, rt_q);
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
                    stall       = 1'b0;
                    bus_timeout = 1'b1;
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            op_q             <= '0;
            off_q            <= '0;
            rt_q             <= '0;
            is_read_q        <= 1'b0;
            wait_cnt_q       <= '0;
            load_data_q      <= '0;
            avm_address_q    <= '0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_writedata_q  <= '0;
            avm_byteenable_q <= '0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            off_q            <= off_d;
            rt_q             <= rt_d;
            is_read_q        <= is_read_d;
            wait_cnt_q       <= wait_cnt_d;
            load_data_q      <= load_data_d;
            avm_address_q    <= avm_address_d;
            avm_read_q       <= avm_read_d;
            avm_write_q      <= avm_write_d;
            avm_writedata_q  <= avm_writedata_d;
            avm_byteenable_q <= avm_byteenable_d;
        end
    end

    assign load_valid     = (state_q == DONE) && is_read_q;
    assign load_data      = load_data_q;
    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_byteenable = avm_byteenable_q;

endmodule
